// File: rtl/mult_div_sequencer.sv
// mult_div_sequencer: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO.
// Shift-add multiply and restoring divide retire one bit per clock.
// Optional build macro MULT_DIV_SIGNED_EN enables signed MULT/DIV (op_i[1]);
// without it every op is unsigned and PREP/FIX are pass-through cycles.
module mult_div_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic                  hi_we_i,
  input  logic                  lo_we_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic            op_div_r;
  logic            dz_r;
  logic [W-1:0]    a_r, b_r, a_mag, b_mag, opnd;
  logic [2*W-1:0]  prod, mul_next, div_next;
  logic [W:0]      mul_sum, div_sh;
  logic            div_ge;
  logic [W-1:0]    div_rem;
  logic [W-1:0]    res_hi, res_lo;
  logic [W-1:0]    hi_r, lo_r;
  logic            accept, busy, div_zero;

`ifdef MULT_DIV_SIGNED_EN
  logic            sgn_r, neg_q, neg_r;

  // Conditional two's-complement negation, operand width.
  function automatic logic [W-1:0] neg_w(input logic [W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  // Conditional two's-complement negation, product width.
  function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  assign a_mag = neg_w(a_r, sgn_r && a_r[W-1]);
  assign b_mag = neg_w(b_r, sgn_r && b_r[W-1]);
`else
  logic            unused_op_sign;

  assign unused_op_sign = op_i[1];
  assign a_mag          = a_r;
  assign b_mag          = b_r;
`endif

  assign busy     = (state == S_PREP) || (state == S_RUN) || (state == S_FIX);
  assign accept   = start_i && ((state == S_IDLE) || (state == S_DONE));
  assign div_zero = op_div_r && (b_r == '0);

  // One iteration step for each algorithm; prod holds {acc/remainder, multiplier/quotient}.
  assign mul_sum  = {1'b0, prod[2*W-1:W]} + (prod[0] ? {1'b0, opnd} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, prod[W-1:1]};
  assign div_sh   = {prod[2*W-1:W], prod[W-1]};
  assign div_ge   = (div_sh >= {1'b0, opnd});
  assign div_rem  = div_ge ? (div_sh[W-1:0] - opnd) : div_sh[W-1:0];
  assign div_next = {div_rem, prod[W-2:0], div_ge};

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (start_i) state_n = S_PREP;
      S_PREP: state_n = div_zero ? S_DONE : S_RUN;
      S_RUN:  if (cnt == CW'(1)) state_n = S_FIX;
      S_FIX:  state_n = S_DONE;
      S_DONE: state_n = start_i ? S_PREP : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operand capture and iterative datapath; no reset, contents are don't-care until PREP.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_div_r <= op_i[0];
      a_r      <= rs_data_i;
      b_r      <= rt_data_i;
`ifdef MULT_DIV_SIGNED_EN
      sgn_r    <= op_i[1];
`endif
    end
    if (state == S_PREP) begin
      prod <= {{W{1'b0}}, op_div_r ? a_mag : b_mag};
      opnd <= op_div_r ? b_mag : a_mag;
`ifdef MULT_DIV_SIGNED_EN
      neg_q <= sgn_r && (a_r[W-1] ^ b_r[W-1]);
      neg_r <= sgn_r && a_r[W-1];
`endif
    end else if (state == S_RUN) begin
      prod <= op_div_r ? div_next : mul_next;
    end
  end

  // Sign correction applied while in FIX; the result is written to HI/LO on the edge into DONE.
  always_comb begin
    res_hi = prod[2*W-1:W];
    res_lo = prod[W-1:0];
`ifdef MULT_DIV_SIGNED_EN
    if (!op_div_r) begin
      {res_hi, res_lo} = neg_2w(prod, neg_q);
    end else begin
      res_lo = neg_w(prod[W-1:0], neg_q);
      res_hi = neg_w(prod[2*W-1:W], neg_r);
    end
`endif
  end

  // Iteration counter, divide-by-zero flag and architectural HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      dz_r <= 1'b0;
      hi_r <= '0;
      lo_r <= '0;
    end else begin
      if (accept) dz_r <= 1'b0;
      if (state == S_PREP) begin
        cnt  <= CW'(W);
        dz_r <= div_zero;
      end else if (state == S_RUN) begin
        cnt <= cnt - CW'(1);
      end
      if (!busy) begin
        if (hi_we_i) hi_r <= wr_data_i;
        if (lo_we_i) lo_r <= wr_data_i;
      end
      if (state == S_FIX) begin
        hi_r <= res_hi;
        lo_r <= res_lo;
      end
    end
  end

  assign busy_o        = busy;
  assign done_o        = (state == S_DONE);
  assign div_by_zero_o = (state == S_DONE) && dz_r;
  assign hi_o          = hi_r;
  assign lo_o          = lo_r;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Self-checking bench for mult_div_sequencer: directed vector table, hand-written
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_mult_div_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] rs_data_i = '0;
  logic [W-1:0] rt_data_i = '0;
  logic         hi_we_i = 1'b0;
  logic         lo_we_i = 1'b0;
  logic [W-1:0] wr_data_i = '0;
  logic         busy_o, done_o, div_by_zero_o;
  logic [W-1:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_hi = '0;
  logic [W-1:0] exp_lo = '0;

  typedef struct {
    string      nm;
    logic [1:0] op;
    logic [31:0] a, b, hi, lo;
  } vec_t;
  vec_t vecs[$];

  mult_div_sequencer #(.DATA_WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wr_data_i(wr_data_i),
    .busy_o(busy_o), .done_o(done_o), .div_by_zero_o(div_by_zero_o),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic add_vec(input string nm, input logic [1:0] op,
                         input logic [31:0] a, b, hi, lo);
    vec_t v;
    v.nm = nm; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  // Reference: plain 64-bit arithmetic; SV '/' and '%' truncate toward zero.
  task automatic model(input logic [1:0] op, input logic [31:0] a, b,
                       output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic sgn;
    longint sa, sb, q, r;
    logic [63:0] p;
`ifdef MULT_DIV_SIGNED_EN
    sgn = op[1];
`else
    sgn = 1'b0;
`endif
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = exp_hi;
    lo = exp_lo;
    if (!op[0]) begin
      if (sgn) p = 64'(sa * sb);
      else     p = {32'b0, a} * {32'b0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (b == 0) begin
      dz = 1'b1;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // MTHI/MTLO while idle; entered and left on a falling edge.
  task automatic do_write(input logic hw, input logic lw, input logic [31:0] d);
    hi_we_i = hw; lo_we_i = lw; wr_data_i = d;
    @(negedge clk);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    if (hw) exp_hi = d;
    if (lw) exp_lo = d;
    check("mt_hi", hi_o, exp_hi);
    check("mt_lo", lo_o, exp_lo);
  endtask

  // Issue one op at the current falling edge (cycle 0) and follow it to DONE.
  // glitch_cyc: cycle in which a stray start_i is pulsed; wr_cyc: cycle of an MTLO 0x5678.
  task automatic do_op(input string nm, input logic [1:0] op, input logic [31:0] a, b,
                       input logic [31:0] ehi, elo, input logic edz,
                       input int glitch_cyc, input int wr_cyc);
    int n;
    int exp_lat;
    bit busy_bad;
    exp_lat = edz ? 2 : W + 3;
    busy_bad = 0;
    start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b;
    if (wr_cyc == 0) begin
      lo_we_i = 1'b1; wr_data_i = 32'h5678;
    end
    n = 0;
    @(negedge clk);
    n = 1;
    start_i = 1'b0; lo_we_i = 1'b0;
    if (wr_cyc == 0) check({nm, "_same_edge_mtlo"}, lo_o, 32'h5678);
    while (!done_o && n < W + 10) begin
      if (!busy_o) busy_bad = 1;
      if (n == glitch_cyc) begin
        start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'h3; rt_data_i = 32'h9;
      end
      if (n == wr_cyc) begin
        lo_we_i = 1'b1; wr_data_i = 32'h5678;
      end
      @(negedge clk);
      n++;
      start_i = 1'b0; lo_we_i = 1'b0;
      if (wr_cyc > 0 && n == wr_cyc + 1) check({nm, "_busy_mtlo"}, lo_o, exp_lo);
    end
    check({nm, "_latency"}, n, exp_lat);
    check({nm, "_busy_held"}, busy_bad, 0);
    check({nm, "_done"}, done_o, 1'b1);
    check({nm, "_busy_in_done"}, busy_o, 1'b0);
    check({nm, "_dz"}, div_by_zero_o, edz);
    check({nm, "_hi"}, hi_o, ehi);
    check({nm, "_lo"}, lo_o, elo);
    exp_hi = ehi;
    exp_lo = elo;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ehi, elo, a, b;
    logic edz, seen;
    logic [1:0] op;

`ifdef MULT_DIV_SIGNED_EN
    add_vec("mult_m3x5",    2'b10, 32'hFFFF_FFFD, 32'h5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);
    add_vec("div_m7d2",     2'b11, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    add_vec("div_min_m1",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
    add_vec("div_7dm2",     2'b11, 32'h7,         32'hFFFF_FFFE, 32'h1,         32'hFFFF_FFFD);
    add_vec("mult_min_sq",  2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
`else
    add_vec("mult_uns_fffd", 2'b10, 32'hFFFF_FFFD, 32'h5,        32'h4,         32'hFFFF_FFF1);
    add_vec("div_uns_min",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
`endif
    add_vec("multu_max",    2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    add_vec("divu_100_7",   2'b01, 32'd100,       32'd7,         32'd2,         32'd14);
    add_vec("multu_6x7",    2'b00, 32'd6,         32'd7,         32'd0,         32'd42);
    add_vec("divu_max_1",   2'b01, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'hFFFF_FFFF);
    add_vec("divu_5_10",    2'b01, 32'd5,         32'd10,        32'd5,         32'd0);

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_dz", div_by_zero_o, 1'b0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    @(negedge clk);

    // MTHI in IDLE lands on the next edge
    do_write(1'b1, 1'b0, 32'h1234);

    // Directed vectors
    for (int i = 0; i < vecs.size(); i++) begin
      do_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, -1, -1);
      @(negedge clk);
      check({vecs[i].nm, "_done_pulse"}, done_o, 1'b0);
    end

    // DIVU 100/7 with a stray start_i in RUN cycle 5 (cycle 6 after accept)
    do_op("divu_glitch", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 6, -1);
    @(negedge clk);

    // MTLO while busy is ignored
    do_op("multu_busy_wr", 2'b00, 32'd9, 32'd9, 32'd0, 32'd81, 1'b0, -1, 8);
    @(negedge clk);

    // MTLO on the same edge as start lands, then the result overwrites it
    exp_lo = 32'h5678;
    do_op("multu_same_wr", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, -1, 0);
    @(negedge clk);

    // Divide by zero keeps preloaded HI/LO
    do_write(1'b1, 1'b1, 32'hAAAA);
    do_op("divu_zero", 2'b01, 32'h55, 32'h0, 32'hAAAA, 32'hAAAA, 1'b1, -1, -1);

    // Back-to-back: next op issued in the DONE cycle of the previous one
    do_op("b2b_first", 2'b00, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, -1, -1);
    do_op("b2b_second", 2'b01, 32'd1000, 32'd10, 32'd0, 32'd100, 1'b0, -1, -1);
    @(negedge clk);

    // Reset in RUN cycle 10 discards the operation
    start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'h1234; rt_data_i = 32'h5678;
    @(negedge clk);
    start_i = 1'b0;
    for (int n = 1; n < 11; n++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_done", done_o, 1'b0);
    check("midrst_hi", hi_o, 32'h0);
    check("midrst_lo", lo_o, 32'h0);
    seen = 1'b0;
    repeat (W + 8) begin
      @(negedge clk);
      if (done_o) seen = 1'b1;
    end
    check("midrst_no_done", seen, 1'b0);
    do_op("after_rst_6x7", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, -1, -1);
    @(negedge clk);

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      op = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      model(op, a, b, ehi, elo, edz);
      do_op("rand", op, a, b, ehi, elo, edz, -1, -1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
